// File: rtl/capture_trigger.sv
`default_nettype none
// ============================================================================
//  Module   : capture_trigger
//  Purpose  : Trigger and capture controller for the waveform RAM fill path.
//             After arm, discards HOLDOFF valid samples, then waits for a
//             level crossing on the selected edge (or an auto-trigger
//             timeout) and writes exactly DEPTH consecutive samples to RAM
//             addresses 0..DEPTH-1 before raising done.
//  Ports    : clk, reset (async, active-high)
//             arm, abort                 - control from display sequencer
//             sample_valid, sample       - scaled ADC stream
//             trig_level, trig_edge      - threshold and edge (0 rise, 1 fall)
//             auto_en                    - enables auto-trigger timeout
//             wr_en, wr_addr, wr_data    - registered RAM write port
//             busy, done, auto_trig      - status
//             state_dbg                  - encoded state
//  Revision : 1.0 - initial release
// ============================================================================
module capture_trigger #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 160,
  parameter int HOLDOFF = 4,
  parameter int TIMEOUT = 50000,
  parameter int TO_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic              auto_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              auto_trig,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_HOLDOFF   = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_CAPTURE   = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  // Holdoff counter only needs to reach HOLDOFF-1.
  localparam int                HO_W      = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [HO_W-1:0]   HO_LAST   = HO_W'(HOLDOFF - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  state_t              r_state,   w_state_nxt;
  logic [DATA_W-1:0]   r_prev,    w_prev_nxt;
  logic [HO_W-1:0]     r_ho_cnt,  w_ho_cnt_nxt;
  logic [TO_W-1:0]     r_to_cnt,  w_to_cnt_nxt;
  logic [ADDR_W-1:0]   r_addr,    w_addr_nxt;
  logic                w_wr_en_nxt;
  logic [ADDR_W-1:0]   w_wr_addr_nxt;
  logic [DATA_W-1:0]   w_wr_data_nxt;
  logic                w_done_nxt;
  logic                w_auto_nxt;
  logic                w_busy_nxt;

  logic w_rise, w_fall, w_edge_hit;

  // Unsigned level-crossing detection against the previous valid sample.
  assign w_rise     = (r_prev < trig_level) && (sample >= trig_level);
  assign w_fall     = (r_prev > trig_level) && (sample <= trig_level);
  assign w_edge_hit = sample_valid && (trig_edge ? w_fall : w_rise);

  assign state_dbg  = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_prev    <= '0;
      r_ho_cnt  <= '0;
      r_to_cnt  <= '0;
      r_addr    <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      auto_trig <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_prev    <= w_prev_nxt;
      r_ho_cnt  <= w_ho_cnt_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_addr    <= w_addr_nxt;
      wr_en     <= w_wr_en_nxt;
      wr_addr   <= w_wr_addr_nxt;
      wr_data   <= w_wr_data_nxt;
      busy      <= w_busy_nxt;
      done      <= w_done_nxt;
      auto_trig <= w_auto_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_prev_nxt    = r_prev;
    w_ho_cnt_nxt  = r_ho_cnt;
    w_to_cnt_nxt  = r_to_cnt;
    w_addr_nxt    = r_addr;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = wr_addr;
    w_wr_data_nxt = wr_data;
    w_done_nxt    = done;
    w_auto_nxt    = auto_trig;

    if (abort) begin
      // Abort beats arm and suppresses any write in this cycle.
      w_state_nxt = S_IDLE;
      w_done_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // done is raised one cycle after the final write is presented.
          if (r_state == S_DONE) w_done_nxt = 1'b1;
          if (arm) begin
            w_state_nxt  = S_HOLDOFF;
            w_done_nxt   = 1'b0;
            w_auto_nxt   = 1'b0;
            w_ho_cnt_nxt = '0;
            w_to_cnt_nxt = '0;
            w_addr_nxt   = '0;
          end
        end

        S_HOLDOFF: begin
          if (sample_valid) begin
            w_prev_nxt = sample;
            if (r_ho_cnt == HO_LAST) w_state_nxt  = S_WAIT_TRIG;
            else                     w_ho_cnt_nxt = r_ho_cnt + 1'b1;
          end
        end

        S_WAIT_TRIG: begin
          // Counter saturates so auto_en=0 simply waits forever.
          if (r_to_cnt != TO_LAST) w_to_cnt_nxt = r_to_cnt + 1'b1;
          if (sample_valid) w_prev_nxt = sample;
          if (w_edge_hit) begin
            // Triggering sample is itself the first stored sample.
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = '0;
            w_wr_data_nxt = sample;
            if (ADDR_LAST == '0) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_CAPTURE;
              w_addr_nxt  = ADDR_W'(1);
            end
          end else if (auto_en && (r_to_cnt == TO_LAST)) begin
            w_state_nxt = S_CAPTURE;
            w_addr_nxt  = '0;
            w_auto_nxt  = 1'b1;
          end
        end

        S_CAPTURE: begin
          if (sample_valid) begin
            w_wr_en_nxt   = 1'b1;
            w_wr_addr_nxt = r_addr;
            w_wr_data_nxt = sample;
            if (r_addr == ADDR_LAST) w_state_nxt = S_DONE;
            else                     w_addr_nxt  = r_addr + 1'b1;
          end
        end

        default: w_state_nxt = S_IDLE;
      endcase
    end

    w_busy_nxt = (w_state_nxt == S_HOLDOFF) || (w_state_nxt == S_WAIT_TRIG) ||
                 (w_state_nxt == S_CAPTURE);
  end

endmodule
`default_nettype wire

// File: tb/tb_capture_trigger.sv
`default_nettype none
// ============================================================================
//  Module   : tb_capture_trigger
//  Purpose  : Self-checking bench for capture_trigger. Stimulus pushes the
//             expected RAM writes into a queue; a monitor pops and compares
//             every presented write. Status outputs are checked directly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_capture_trigger;

  localparam int DEPTH = 160;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       arm = 1'b0;
  logic       abort = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] sample = '0;
  logic [7:0] trig_level = '0;
  logic       trig_edge = 1'b0;
  logic       auto_en = 1'b0;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy, done, auto_trig;
  logic [2:0] state_dbg;

  capture_trigger #(
    .DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .HOLDOFF(4), .TIMEOUT(20), .TO_W(16)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort),
    .sample_valid(sample_valid), .sample(sample), .trig_level(trig_level),
    .trig_edge(trig_edge), .auto_en(auto_en), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .auto_trig(auto_trig),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  wr_t exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, req);
  endtask

  // Write monitor: every presented write must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write actual=addr %0d data %0d required=no write",
                 wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.a));
        chk("wr_data", 32'(wr_data), 32'(e.d));
      end
    end
  end

  // One clock: inputs applied just after a rising edge, held until the next.
  task automatic step(input logic v, input logic [7:0] s);
    sample_valid = v;
    sample       = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step(1'b0, 8'd0);
    arm = 1'b0;
  endtask

  function automatic logic [7:0] pat(input int a);
    return 8'(a) ^ 8'h5A;
  endfunction

  task automatic expect_wr(input int a, input logic [7:0] d);
    wr_t e;
    e.a = 8'(a);
    e.d = d;
    exp_q.push_back(e);
  endtask

  // Capture addresses first..DEPTH-1, optionally with an idle cycle before each.
  task automatic capture_from(input int first, input bit gapped);
    for (int a = first; a < DEPTH; a++) begin
      if (gapped) step(1'b0, 8'hFF);
      expect_wr(a, pat(a));
      step(1'b1, pat(a));
    end
  endtask

  // Arm, then rising trigger at level 100: holdoff eats 70..85, 100 triggers.
  task automatic arm_rising_trigger();
    trig_level = 8'd100;
    trig_edge  = 1'b0;
    do_arm();
    step(1'b1, 8'd70); step(1'b1, 8'd75); step(1'b1, 8'd80); step(1'b1, 8'd85);
    chk("holdoff_to_wait_state", 32'(state_dbg), 32'd2);
    step(1'b1, 8'd90);
    step(1'b1, 8'd95);
    expect_wr(0, 8'd100);
    step(1'b1, 8'd100);
    chk("rise_trig_state", 32'(state_dbg), 32'd3);
  endtask

  task automatic finish_done(input string tag, input logic exp_auto);
    chk({tag, "_done_lag"}, 32'(done), 32'd0);
    step(1'b0, 8'd0);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_state"}, 32'(state_dbg), 32'd4);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_auto"}, 32'(auto_trig), 32'(exp_auto));
    chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_auto", 32'(auto_trig), 32'd0);
    chk("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    step(1'b0, 8'd0);

    // Rising trigger, full capture
    arm_rising_trigger();
    capture_from(1, 1'b0);
    finish_done("rise", 1'b0);
    step(1'b0, 8'd0);
    chk("done_holds", 32'(done), 32'd1);

    // Falling trigger with gapped valid; arm from DONE clears done
    trig_level = 8'd50;
    trig_edge  = 1'b1;
    do_arm();
    chk("arm_clears_done", 32'(done), 32'd0);
    chk("arm_holdoff_state", 32'(state_dbg), 32'd1);
    repeat (4) step(1'b1, 8'd70);
    step(1'b1, 8'd60);
    step(1'b1, 8'd55);
    step(1'b1, 8'd52);
    chk("fall_no_early_trig", 32'(state_dbg), 32'd2);
    expect_wr(0, 8'd50);
    step(1'b1, 8'd50);
    capture_from(1, 1'b1);
    finish_done("fall_gap", 1'b0);

    // Auto trigger after 20 cycles in WAIT_TRIG
    trig_level = 8'd100;
    trig_edge  = 1'b0;
    auto_en    = 1'b1;
    do_arm();
    repeat (4) step(1'b1, 8'd10);
    repeat (19) step(1'b1, 8'd10);
    chk("auto_not_yet", 32'(auto_trig), 32'd0);
    chk("auto_not_yet_state", 32'(state_dbg), 32'd2);
    step(1'b1, 8'd10);
    chk("auto_fired", 32'(auto_trig), 32'd1);
    chk("auto_capture_state", 32'(state_dbg), 32'd3);
    capture_from(0, 1'b0);
    finish_done("auto", 1'b1);

    // auto_en=0: waits indefinitely with no writes
    auto_en = 1'b0;
    do_arm();
    repeat (1004) step(1'b1, 8'd10);
    chk("noauto_busy", 32'(busy), 32'd1);
    chk("noauto_state", 32'(state_dbg), 32'd2);
    abort = 1'b1;
    step(1'b0, 8'd0);
    abort = 1'b0;

    // Abort at addr 37, with an ignored arm mid-capture, then re-arm
    arm_rising_trigger();
    for (int a = 1; a < 37; a++) begin
      arm = (a == 10);
      expect_wr(a, pat(a));
      step(1'b1, pat(a));
    end
    arm   = 1'b0;
    abort = 1'b1;
    step(1'b1, pat(37));
    abort = 1'b0;
    chk("abort_state", 32'(state_dbg), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wr_en", 32'(wr_en), 32'd0);
    repeat (5) step(1'b1, 8'd200);
    arm_rising_trigger();
    capture_from(1, 1'b0);
    finish_done("rearm", 1'b0);

    // Asynchronous reset mid-cycle during CAPTURE
    arm_rising_trigger();
    for (int a = 1; a < 6; a++) begin
      expect_wr(a, pat(a));
      step(1'b1, pat(a));
    end
    @(negedge clk);
    #1;
    chk("pre_reset_wr_en", 32'(wr_en), 32'd1);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("areset_wr_en", 32'(wr_en), 32'd0);
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_done", 32'(done), 32'd0);
    chk("areset_wr_addr", 32'(wr_addr), 32'd0);
    chk("areset_state", 32'(state_dbg), 32'd0);
    chk("areset_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
